ycfg_loader: RTL and testbench
==============================

// Module: ycfg_loader
// PURPOSE
//  - Upstream feeder of a ycell column's configuration chain (cbitin -> ... -> cbitout).
//  - Takes configuration words over a valid/ready port and serialises them MSB first onto cbitin.
//  - Generates the confclk strobes on the single system clock.
//  - Captures the bits falling out of the chain end (cbitout) into readback words, so software can verify or save the old configuration.
// PARAMETERS
//  W         8  configuration word width (bits per accepted word)
//  SETUP_CYC 2  cycles cbitin is stable with confclk low before the rising strobe (>=1)
//  HIGH_CYC  2  cycles confclk is held high (>=1)
// PORTS
//  clk       in   1  system clock; only clock in the block
//  reset     in   1  synchronous, active-high; clears all state
//  in_valid  in   1  configuration word offered
//  in_ready  out  1  loader can accept a word this cycle
//  in_data   in   W  configuration word, in_data[W-1] shifted first
//  in_last   in   1  word is the final word of a configuration frame
//  confclk   out  1  strobe to the chain's first ycell
//  cbitin    out  1  configuration bit to the chain's first ycell
//  cbitout   in   1  configuration bit returned from the chain's last ycell
//  rb_valid  out  1  one-cycle pulse: rb_data holds a complete readback word
//  rb_data   out  W  bits captured from cbitout, first captured bit in [W-1]
//  busy      out  1  high from word accept until that word's last HOLD completes
//  done      out  1  one-cycle pulse when a word tagged in_last finishes
// BEHAVIOUR
//  - All outputs are registered. Reset values: confclk=0, cbitin=0, in_ready=1, busy=0, rb_valid=0, done=0, rb_data=0.
//  - States: IDLE, SETUP, HIGH, HOLD.
//    - IDLE: in_ready=1. On in_valid&&in_ready at edge k:
//      - latch in_data and in_last; set bit counter to W-1.
//      - cbitin<=in_data[W-1]; in_ready<=0; busy<=1; go to SETUP.
//    - SETUP: confclk=0 for SETUP_CYC cycles. On the last SETUP cycle, sample cbitout into the readback shift register, then set confclk<=1 and go to HIGH.
//    - HIGH: confclk=1 for HIGH_CYC cycles, then confclk<=0 and go to HOLD.
//    - HOLD: exactly 1 cycle with confclk=0 and cbitin unchanged (hold time for the asynchronous cell). Then:
//      - if bits remain: cbitin<=next bit, counter--, go to SETUP;
//      - otherwise: go to IDLE with in_ready<=1 and busy<=0, pulse rb_valid, and pulse done if the latched in_last was set.
//  - Timing:
//    - bit period = SETUP_CYC+HIGH_CYC+1 cycles; a word takes W*(SETUP_CYC+HIGH_CYC+1) cycles.
//    - confclk first rises at edge k+SETUP_CYC.
//    - cbitin changes only at edges where confclk is low before and after.
//  - Back-to-back words: in_ready rises at the edge that ends the last HOLD; the next accept comes at the following edge at the earliest (one IDLE cycle between words).
//  - Words are never accepted while busy. in_data and in_last are ignored unless in_valid&&in_ready.
//  - rb_data stays stable until the next rb_valid. rb_valid and done are never high while reset=1.
//  - Reset mid-operation: at the next edge, confclk=0 and cbitin=0, state=IDLE, the word is dropped, and no rb_valid or done is issued. The chain contents are left partially shifted; the host must reload the full frame.
//  - Frame length is not checked; the host sends exactly (cells*bits_per_cell)/W words.
// STRUCTURE
//  - Shared package/include ycfg_defs: state encoding (IDLE/SETUP/HIGH/HOLD) and default SETUP_CYC/HIGH_CYC.
//  - One natural sub-module: ycfg_strobe_timer.
//    - Contains the cycle counter and the SETUP/HIGH/HOLD sequencing for one bit.
//    - Interface: start, sample, bit_done.
//  - The top level holds the word and readback shift registers, the bit counter and the handshake.
// TESTING (W=8, SETUP_CYC=2, HIGH_CYC=2 unless noted)
//  1. Reset: hold reset 3 cycles with in_valid=1 -> confclk=0, cbitin=0, in_ready=1, busy=0, no accept.
//  2. Single word: offer 8'hA5 with in_last=1 ->
//     - cbitin sequence 1,0,1,0,0,1,0,1;
//     - 8 confclk pulses, each 2 cycles high and 5 cycles apart;
//     - in_ready back at accept+40; done pulses exactly once.
//  3. Readback: loop cbitout through an 8-bit shift-register chain model; load 8'hA5, then 8'h3C -> second rb_data=8'hA5, rb_valid pulses once per word.
//  4. Backpressure: hold in_valid with 8'h0F during a load -> in_ready=0 throughout; accepted one cycle after in_ready rises; first cbitin=0.
//  5. Reset mid-strobe: assert reset during HIGH of bit 3 -> confclk=0 at next edge, no rb_valid, no done, fresh load works.
//  6. Integration: column of ycells, shift a full frame, then a second frame of zeros -> readback reproduces the first frame bit-exact.

Source files
------------

// File: rtl/ycfg_loader_pkg.sv
// Shared definitions for the ycell configuration loader: per-bit strobe phases
// and default parameter values.
package ycfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } ycfg_state_e;

  localparam int DEF_W         = 8;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_HIGH_CYC  = 2;

endpackage

// File: rtl/ycfg_loader_if.sv
// Valid/ready configuration word port between the host and the loader.
interface ycfg_loader_if #(
  parameter int W = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/ycfg_loader_strobe_timer.sv
// Per-bit strobe sequencer: SETUP (confclk low), HIGH (confclk high), HOLD
// (one low cycle). sample and bit_done are combinational qualifiers for the
// edge that ends the last SETUP cycle and the HOLD cycle respectively.
module ycfg_strobe_timer
  import ycfg_loader_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HIGH_CYC  = DEF_HIGH_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic sample,
  output logic bit_done,
  output logic confclk
);

  localparam int CMAX = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  ycfg_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          confclk_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      confclk <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      confclk <= confclk_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    confclk_n = confclk;
    sample    = 1'b0;
    bit_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        confclk_n = 1'b0;
        if (start) begin
          state_n = ST_SETUP;
          cnt_n   = '0;
        end
      end
      ST_SETUP: begin
        confclk_n = 1'b0;
        if (cnt == CW'(SETUP_CYC - 1)) begin
          sample    = 1'b1;
          confclk_n = 1'b1;
          state_n   = ST_HIGH;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_HIGH: begin
        confclk_n = 1'b1;
        if (cnt == CW'(HIGH_CYC - 1)) begin
          confclk_n = 1'b0;
          state_n   = ST_HOLD;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        confclk_n = 1'b0;
        bit_done  = 1'b1;
        cnt_n     = '0;
        state_n   = start ? ST_SETUP : ST_IDLE;
      end
      default: begin
        confclk_n = 1'b0;
        state_n   = ST_IDLE;
        cnt_n     = '0;
      end
    endcase
  end

endmodule

// File: rtl/ycfg_loader.sv
// Configuration chain feeder: serialises accepted words MSB first onto cbitin
// with confclk strobes and assembles the bits returned on cbitout into readback words.
module ycfg_loader
  import ycfg_loader_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HIGH_CYC  = DEF_HIGH_CYC
) (
  input  logic          clk,
  input  logic          reset,
  ycfg_loader_if.slave  cfg,
  output logic          confclk,
  output logic          cbitin,
  input  logic          cbitout,
  output logic          rb_valid,
  output logic [W-1:0]  rb_data,
  output logic          busy,
  output logic          done
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic          ready_q;
  logic [W-1:0]  word_q;
  logic [W-1:0]  rb_shift;
  logic          last_q;
  logic [BW-1:0] bit_cnt;

  logic accept;
  logic more;
  logic start;
  logic sample;
  logic bit_done;

  assign cfg.in_ready = ready_q;
  assign accept       = cfg.in_valid && ready_q;
  assign more         = (bit_cnt != '0);
  // The timer is restarted straight out of HOLD so bits run back-to-back.
  assign start        = accept || (bit_done && more);

  ycfg_strobe_timer #(
    .SETUP_CYC (SETUP_CYC),
    .HIGH_CYC  (HIGH_CYC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sample   (sample),
    .bit_done (bit_done),
    .confclk  (confclk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      word_q   <= '0;
      last_q   <= 1'b0;
      bit_cnt  <= '0;
      cbitin   <= 1'b0;
      rb_shift <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      done     <= 1'b0;

      if (accept) begin
        word_q  <= cfg.in_data;
        last_q  <= cfg.in_last;
        bit_cnt <= BW'(W - 1);
        cbitin  <= cfg.in_data[W-1];
        ready_q <= 1'b0;
        busy    <= 1'b1;
      end

      if (sample) begin
        rb_shift <= {rb_shift[W-2:0], cbitout};
      end

      if (bit_done) begin
        if (more) begin
          bit_cnt <= bit_cnt - BW'(1);
          cbitin  <= word_q[W-2];
          word_q  <= {word_q[W-2:0], 1'b0};
        end else begin
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          rb_valid <= 1'b1;
          rb_data  <= rb_shift;
          done     <= last_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycfg_loader.sv
// Directed + randomized bench for ycfg_loader with a behavioural configuration chain.
module tb_ycfg_loader;
  import ycfg_loader_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int H  = 2;
  localparam int P  = S + H + 1;
  localparam int WC = W * P;

  logic         clk;
  logic         reset;
  logic         confclk, cbitin, cbitout;
  logic         rb_valid, busy, done;
  logic [W-1:0] rb_data;

  ycfg_loader_if #(.W(W)) cfg ();

  ycfg_loader #(.W(W), .SETUP_CYC(S), .HIGH_CYC(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg      (cfg),
    .confclk  (confclk),
    .cbitin   (cbitin),
    .cbitout  (cbitout),
    .rb_valid (rb_valid),
    .rb_data  (rb_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column of ycells: a shift chain clocked by confclk.
  logic [63:0] chain;
  logic        chain_clr;
  int          chain_len;
  always @(posedge confclk or posedge chain_clr)
    if (chain_clr) chain <= '0;
    else           chain <= {chain[62:0], cbitin};
  assign cbitout = chain[chain_len-1];

  // Reference: bits leaving the chain are its old contents followed by every bit sent.
  bit           stream[$];
  int           words_sent;
  logic [W-1:0] rb_hold;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rb(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = stream[n*W + i];
    return r;
  endfunction

  task automatic chain_init(input int len);
    chain_len  = len;
    chain_clr  = 1'b1;
    #1;
    chain_clr  = 1'b0;
    stream.delete();
    for (int i = 0; i < len; i++) stream.push_back(1'b0);
    words_sent = 0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic l,
                           input logic nv, input logic [W-1:0] nd,
                           output logic [W-1:0] rb, output int waited);
    int n;
    logic [W-1:0] e;
    cfg.in_valid = 1'b1;
    cfg.in_data  = d;
    cfg.in_last  = l;
    waited = 0;
    while (!cfg.in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_wait", waited < 200, 1);
    @(posedge clk); #1;
    for (int i = W - 1; i >= 0; i--) stream.push_back(d[i]);
    n = words_sent;
    words_sent++;
    cfg.in_valid = nv;
    cfg.in_data  = nv ? nd : W'($urandom);
    cfg.in_last  = nv ? 1'b0 : 1'($urandom);
    chk("t0_ready", cfg.in_ready, 0);
    chk("t0_busy", busy, 1);
    chk("t0_cbitin", cbitin, d[W-1]);
    chk("t0_confclk", confclk, 0);
    chk("t0_rb_valid", rb_valid, 0);
    chk("t0_done", done, 0);
    chk("t0_rb_stable", rb_data, rb_hold);
    for (int t = 1; t <= WC; t++) begin
      @(posedge clk); #1;
      if (!nv) begin
        cfg.in_data = W'($urandom);
        cfg.in_last = 1'($urandom);
      end
      if (t < WC) begin
        chk($sformatf("confclk@%0d", t), confclk, ((t % P) >= S) && ((t % P) < S + H));
        chk($sformatf("cbitin@%0d", t), cbitin, d[W-1-t/P]);
        chk($sformatf("ready@%0d", t), cfg.in_ready, 0);
        chk($sformatf("busy@%0d", t), busy, 1);
        chk($sformatf("rbv@%0d", t), rb_valid, 0);
      end else begin
        e = exp_rb(n);
        chk("end_ready", cfg.in_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_confclk", confclk, 0);
        chk("end_rb_valid", rb_valid, 1);
        chk("end_done", done, l);
        chk("end_rb_data", rb_data, e);
        rb = rb_data;
        rb_hold = e;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, "_rbv"}, rb_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] frame [4];
    int waited;
    int pulses;

    chain_len    = 8;
    chain_clr    = 1'b0;
    rb_hold      = '0;
    reset        = 1'b1;
    cfg.in_valid = 1'b1;
    cfg.in_data  = 8'hFF;
    cfg.in_last  = 1'b1;

    // Reset held with a word offered
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_confclk", confclk, 0);
      chk("rst_cbitin", cbitin, 0);
      chk("rst_ready", cfg.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rbv", rb_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_rb_data", rb_data, 0);
    end
    reset        = 1'b0;
    cfg.in_valid = 1'b0;
    chain_init(8);
    idle_check("post_rst");

    // Single word, then readback through an 8-bit chain
    send_word(8'hA5, 1'b1, 1'b0, '0, rb, waited);
    idle_check("single");
    send_word(8'h3C, 1'b0, 1'b0, '0, rb, waited);
    chk("readback_a5", rb, 8'hA5);
    idle_check("readback");

    // Backpressure: next word offered throughout the current load
    send_word(8'hA5, 1'b0, 1'b1, 8'h0F, rb, waited);
    send_word(8'h0F, 1'b1, 1'b0, '0, rb, waited);
    chk("bp_immediate", waited, 0);
    idle_check("bp");

    // Reset during HIGH of bit 3
    cfg.in_valid = 1'b1;
    cfg.in_data  = 8'($urandom);
    cfg.in_last  = 1'b1;
    @(posedge clk); #1;
    cfg.in_valid = 1'b0;
    repeat (3 * P + S) @(posedge clk);
    #1;
    chk("mid_high", confclk, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_confclk", confclk, 0);
    chk("mr_cbitin", cbitin, 0);
    chk("mr_ready", cfg.in_ready, 1);
    chk("mr_busy", busy, 0);
    rb_hold = '0;
    pulses = 0;
    repeat (WC + 10) begin
      @(posedge clk); #1;
      if (rb_valid || done || confclk) pulses++;
    end
    chk("mr_no_pulse", pulses, 0);
    chain_init(8);
    send_word(8'($urandom), 1'b1, 1'b0, '0, rb, waited);

    // Integration: 32-cell column, random frame then a frame of zeros
    chain_init(32);
    for (int i = 0; i < 4; i++) begin
      frame[i] = 8'($urandom);
      send_word(frame[i], i == 3, 1'b0, '0, rb, waited);
    end
    for (int i = 0; i < 4; i++) begin
      send_word('0, i == 3, 1'b0, '0, rb, waited);
      chk($sformatf("frame_rb%0d", i), rb, frame[i]);
    end

    // Random words with random gaps on a 16-cell column
    chain_init(16);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) idle_check("gap");
      send_word(8'($urandom), 1'($urandom), 1'b0, '0, rb, waited);
    end
    idle_check("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
